// File: rtl/br_fifo_shared_pstatic_pkg.sv
// Shared helpers for the pseudo-static shared FIFO: region-wrapping pointer add
// and the per-cycle credit-return clamp.
package br_fifo_shared_pstatic_pkg;

  function automatic int unsigned clamped_clog2(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // inc must stay below the region size so a single wrap is enough
  function automatic logic [31:0] wrap_add(input logic [31:0] ptr,
                                           input logic [31:0] inc,
                                           input logic [31:0] base,
                                           input logic [31:0] bound);
    logic [31:0] sum;
    sum = ptr + inc;
    if (sum > bound) sum = sum - (bound - base + 32'd1);
    return sum;
  endfunction

  function automatic logic [31:0] credit_clamp(input logic [31:0] avail,
                                               input logic [31:0] max_ret);
    return (avail > max_ret) ? max_ret : avail;
  endfunction

endpackage

// File: rtl/br_fifo_shared_pstatic_credit_counter_multi.sv
// Per-FIFO receiver credit counter returning up to MaxCreditReturn credits per
// cycle, with withhold, stall gating and an optional registered return.
module br_fifo_shared_pstatic_credit_counter_multi
  import br_fifo_shared_pstatic_pkg::*;
#(
  parameter int CountWidth          = 4,
  parameter int RetWidth            = 2,
  parameter int DeallocWidth        = 2,
  parameter int MaxCreditReturn     = 2,
  parameter int RegisterPushOutputs = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [CountWidth-1:0]   initial_count,
  input  logic [CountWidth-1:0]   withhold,
  input  logic [DeallocWidth-1:0] dealloc,
  output logic [CountWidth-1:0]   count,
  output logic [CountWidth-1:0]   available,
  output logic [RetWidth-1:0]     credit
);

  logic [CountWidth-1:0] count_q;
  logic [RetWidth-1:0]   ret_q;
  logic [RetWidth-1:0]   ret_d;
  logic [RetWidth-1:0]   ret_applied;
  logic [RetWidth-1:0]   pending;
  logic [CountWidth:0]   need;
  logic [CountWidth-1:0] avail_eff;

  // A registered credit is still in the count while it is on the wire, so it
  // is excluded from what may be returned next.
  always_comb begin
    pending     = (RegisterPushOutputs != 0) ? ret_q : '0;
    need        = (CountWidth+1)'(pending) + (CountWidth+1)'(withhold);
    avail_eff   = ({1'b0, count_q} >= need) ? CountWidth'({1'b0, count_q} - need) : '0;
    ret_d       = (rst || stall) ? '0
                : RetWidth'(credit_clamp(32'(avail_eff), MaxCreditReturn));
    ret_applied = (RegisterPushOutputs != 0) ? ret_q : ret_d;
    available   = (count_q >= withhold) ? count_q - withhold : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= initial_count;
      ret_q   <= '0;
    end else begin
      count_q <= count_q + CountWidth'(dealloc) - CountWidth'(ret_applied);
      ret_q   <= ret_d;
    end
  end

  assign count  = count_q;
  assign credit = ret_applied;

endmodule

// File: rtl/br_fifo_shared_pstatic_push_ctrl_credit_mwp.sv
// Multi-write-port push controller for a shared pseudo-static FIFO: per-FIFO
// tails, port-ordered address allocation, credit return. Define
// BR_FIFO_SHARED_PSTATIC_RAM_WR_REG_EN to register ram_wr_*, advance_tail, tail_next.
module br_fifo_shared_pstatic_push_ctrl_credit_mwp
  import br_fifo_shared_pstatic_pkg::*;
#(
  parameter int NumFifos                  = 2,
  parameter int NumWritePorts             = 2,
  parameter int Depth                     = 8,
  parameter int Width                     = 1,
  parameter int MaxDeallocPerCycle        = 2,
  parameter int MaxCreditReturn           = 2,
  parameter int RegisterPushOutputs       = 1,
  parameter int EnableAssertFinalNotValid = 1,
  localparam int AddrWidth    = clamped_clog2(Depth),
  localparam int CountWidth   = $clog2(Depth + 1),
  localparam int FifoIdWidth  = clamped_clog2(NumFifos),
  localparam int RetWidth     = $clog2(MaxCreditReturn + 1),
  localparam int DeallocWidth = $clog2(MaxDeallocPerCycle + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NumFifos*AddrWidth-1:0]       config_base,
  input  logic [NumFifos*AddrWidth-1:0]       config_bound,
  input  logic [NumFifos*CountWidth-1:0]      config_size,
  input  logic                                push_sender_in_reset,
  output logic                                push_receiver_in_reset,
  input  logic [NumFifos-1:0]                 push_credit_stall,
  output logic [NumFifos*RetWidth-1:0]        push_credit,
  input  logic [NumWritePorts-1:0]            push_valid,
  input  logic [NumWritePorts*Width-1:0]      push_data,
  input  logic [NumWritePorts*FifoIdWidth-1:0] push_fifo_id,
  input  logic [NumFifos*CountWidth-1:0]      credit_initial_push,
  input  logic [NumFifos*CountWidth-1:0]      credit_withhold_push,
  output logic [NumFifos*CountWidth-1:0]      credit_count_push,
  output logic [NumFifos*CountWidth-1:0]      credit_available_push,
  output logic [NumWritePorts-1:0]            ram_wr_valid,
  output logic [NumWritePorts*AddrWidth-1:0]  ram_wr_addr,
  output logic [NumWritePorts*Width-1:0]      ram_wr_data,
  output logic [NumFifos-1:0]                 advance_tail,
  output logic [NumFifos*AddrWidth-1:0]       tail_next,
  output logic [NumFifos*AddrWidth-1:0]       tail,
  input  logic [NumFifos*DeallocWidth-1:0]    dealloc_count
);

  logic                              either_rst;
  logic [NumWritePorts-1:0]          push_ok;
  logic [AddrWidth-1:0]              tail_q [NumFifos];
  logic [NumFifos*AddrWidth-1:0]     tail_next_c;
  logic [NumFifos-1:0]               adv_c;
  logic [NumWritePorts*AddrWidth-1:0] wr_addr_c;

  assign either_rst = rst | push_sender_in_reset;
  assign push_ok    = either_rst ? '0 : push_valid;

  // Port p lands after every lower-indexed port pushing to the same FIFO.
  always_comb begin
    logic [FifoIdWidth-1:0] id;
    int unsigned            off;
    id        = '0;
    off       = 0;
    wr_addr_c = '0;
    for (int unsigned p = 0; p < NumWritePorts; p++) begin
      id  = push_fifo_id[p*FifoIdWidth +: FifoIdWidth];
      off = 0;
      for (int unsigned q = 0; q < p; q++) begin
        if (push_ok[q] && (push_fifo_id[q*FifoIdWidth +: FifoIdWidth] == id)) off++;
      end
      wr_addr_c[p*AddrWidth +: AddrWidth] = AddrWidth'(wrap_add(
          32'(tail_q[id]), off,
          32'(config_base[id*AddrWidth +: AddrWidth]),
          32'(config_bound[id*AddrWidth +: AddrWidth])));
    end
  end

  always_comb begin
    int unsigned cnt;
    cnt         = 0;
    tail_next_c = '0;
    adv_c       = '0;
    tail        = '0;
    for (int unsigned f = 0; f < NumFifos; f++) begin
      cnt = 0;
      for (int unsigned p = 0; p < NumWritePorts; p++) begin
        if (push_ok[p] && (push_fifo_id[p*FifoIdWidth +: FifoIdWidth] == FifoIdWidth'(f))) cnt++;
      end
      tail_next_c[f*AddrWidth +: AddrWidth] = AddrWidth'(wrap_add(
          32'(tail_q[f]), cnt,
          32'(config_base[f*AddrWidth +: AddrWidth]),
          32'(config_bound[f*AddrWidth +: AddrWidth])));
      adv_c[f] = (cnt != 0);
      tail[f*AddrWidth +: AddrWidth] = tail_q[f];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned f = 0; f < NumFifos; f++) begin
      if (either_rst) tail_q[f] <= config_base[f*AddrWidth +: AddrWidth];
      else            tail_q[f] <= tail_next_c[f*AddrWidth +: AddrWidth];
    end
  end

`ifdef BR_FIFO_SHARED_PSTATIC_RAM_WR_REG_EN
  // Tail state still advances immediately; only the exported view is delayed.
  always_ff @(posedge clk) begin
    if (either_rst) begin
      ram_wr_valid <= '0;
      advance_tail <= '0;
    end else begin
      ram_wr_valid <= push_ok;
      advance_tail <= adv_c;
    end
    ram_wr_addr <= wr_addr_c;
    ram_wr_data <= push_data;
    tail_next   <= tail_next_c;
  end
`else
  assign ram_wr_valid = push_ok;
  assign ram_wr_addr  = wr_addr_c;
  assign ram_wr_data  = push_data;
  assign advance_tail = adv_c;
  assign tail_next    = tail_next_c;
`endif

  if (RegisterPushOutputs != 0) begin : g_rir_reg
    logic rst_q;
    always_ff @(posedge clk) rst_q <= rst;
    assign push_receiver_in_reset = rst_q;
  end else begin : g_rir_comb
    assign push_receiver_in_reset = rst;
  end

  for (genvar f = 0; f < NumFifos; f++) begin : g_credit
    br_fifo_shared_pstatic_credit_counter_multi #(
      .CountWidth          (CountWidth),
      .RetWidth            (RetWidth),
      .DeallocWidth        (DeallocWidth),
      .MaxCreditReturn     (MaxCreditReturn),
      .RegisterPushOutputs (RegisterPushOutputs)
    ) u_credit_counter (
      .clk           (clk),
      .rst           (either_rst),
      .stall         (push_credit_stall[f]),
      .initial_count (credit_initial_push[f*CountWidth +: CountWidth]),
      .withhold      (credit_withhold_push[f*CountWidth +: CountWidth]),
      .dealloc       (dealloc_count[f*DeallocWidth +: DeallocWidth]),
      .count         (credit_count_push[f*CountWidth +: CountWidth]),
      .available     (credit_available_push[f*CountWidth +: CountWidth]),
      .credit        (push_credit[f*RetWidth +: RetWidth])
    );

    assert property (@(posedge clk) disable iff (either_rst)
      credit_withhold_push[f*CountWidth +: CountWidth] < config_size[f*CountWidth +: CountWidth]);
    assert property (@(posedge clk) disable iff (either_rst)
      32'(dealloc_count[f*DeallocWidth +: DeallocWidth]) <= MaxDeallocPerCycle);
    assert property (@(posedge clk) disable iff (either_rst)
      credit_count_push[f*CountWidth +: CountWidth] <= config_size[f*CountWidth +: CountWidth]);
  end

  for (genvar p = 0; p < NumWritePorts; p++) begin : g_push_chk
    assert property (@(posedge clk) disable iff (either_rst)
      push_valid[p] |-> (32'(push_fifo_id[p*FifoIdWidth +: FifoIdWidth]) < NumFifos));
  end

  assert property (@(posedge clk) either_rst |-> (push_valid == '0));

  final begin
    if (EnableAssertFinalNotValid != 0) assert (push_valid == '0);
  end

endmodule

// File: tb/tb_br_fifo_shared_pstatic_push_ctrl_credit_mwp.sv
// Bench for the multi-write-port shared FIFO push controller: write/tail
// scoreboard plus cycle-exact credit and reset checks.
module tb_br_fifo_shared_pstatic_push_ctrl_credit_mwp;

  localparam int NumFifos = 2;
  localparam int NumWritePorts = 3;
  localparam int Width = 8;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int RW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NumFifos*AW-1:0] config_base, config_bound;
  logic [NumFifos*CW-1:0] config_size;
  logic push_sender_in_reset, push_receiver_in_reset;
  logic [NumFifos-1:0] push_credit_stall;
  logic [NumFifos*RW-1:0] push_credit;
  logic [NumWritePorts-1:0] push_valid;
  logic [NumWritePorts*Width-1:0] push_data;
  logic [NumWritePorts-1:0] push_fifo_id;
  logic [NumFifos*CW-1:0] credit_initial_push, credit_withhold_push;
  logic [NumFifos*CW-1:0] credit_count_push, credit_available_push;
  logic [NumWritePorts-1:0] ram_wr_valid;
  logic [NumWritePorts*AW-1:0] ram_wr_addr;
  logic [NumWritePorts*Width-1:0] ram_wr_data;
  logic [NumFifos-1:0] advance_tail;
  logic [NumFifos*AW-1:0] tail_next, tail;
  logic [NumFifos*2-1:0] dealloc_count;

  br_fifo_shared_pstatic_push_ctrl_credit_mwp #(
    .NumFifos(NumFifos), .NumWritePorts(NumWritePorts), .Depth(8), .Width(Width),
    .MaxDeallocPerCycle(2), .MaxCreditReturn(2), .RegisterPushOutputs(1),
    .EnableAssertFinalNotValid(1)
  ) dut (
    .clk(clk), .rst(rst), .config_base(config_base), .config_bound(config_bound),
    .config_size(config_size), .push_sender_in_reset(push_sender_in_reset),
    .push_receiver_in_reset(push_receiver_in_reset), .push_credit_stall(push_credit_stall),
    .push_credit(push_credit), .push_valid(push_valid), .push_data(push_data),
    .push_fifo_id(push_fifo_id), .credit_initial_push(credit_initial_push),
    .credit_withhold_push(credit_withhold_push), .credit_count_push(credit_count_push),
    .credit_available_push(credit_available_push), .ram_wr_valid(ram_wr_valid),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .advance_tail(advance_tail),
    .tail_next(tail_next), .tail(tail), .dealloc_count(dealloc_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { int unsigned port; logic [AW-1:0] addr; logic [Width-1:0] data; } wr_t;
  typedef struct { logic [NumFifos-1:0] adv; logic [NumFifos*AW-1:0] tnext; } adv_t;
  wr_t  wr_q[$];
  adv_t adv_q[$];

  logic [AW-1:0] tail_m  [NumFifos];
  logic [AW-1:0] base_m  [NumFifos] = '{3'd0, 3'd4};
  logic [AW-1:0] bound_m [NumFifos] = '{3'd3, 3'd7};

  function automatic logic [NumFifos*AW-1:0] flat_tails();
    logic [NumFifos*AW-1:0] r;
    for (int f = 0; f < NumFifos; f++) r[f*AW +: AW] = tail_m[f];
    return r;
  endfunction

  // Output side of the scoreboard: pops whenever the DUT presents a write/advance.
  always @(negedge clk) begin
    wr_t  e;
    adv_t a;
    for (int p = 0; p < NumWritePorts; p++) begin
      if (ram_wr_valid[p]) begin
        if (wr_q.size() == 0) check_eq("wr_unexpected", 32'(ram_wr_valid[p]), 32'd0);
        else begin
          e = wr_q.pop_front();
          check_eq("wr_port", p, e.port);
          check_eq("wr_addr", 32'(ram_wr_addr[p*AW +: AW]), 32'(e.addr));
          check_eq("wr_data", 32'(ram_wr_data[p*Width +: Width]), 32'(e.data));
        end
      end
    end
    if (advance_tail != '0) begin
      if (adv_q.size() == 0) check_eq("adv_unexpected", 32'(advance_tail), 32'd0);
      else begin
        a = adv_q.pop_front();
        check_eq("advance_tail", 32'(advance_tail), 32'(a.adv));
        check_eq("tail_next", 32'(tail_next), 32'(a.tnext));
      end
    end
  end

  task automatic push_cycle(input logic [NumWritePorts-1:0] v, input logic [NumWritePorts-1:0] ids);
    logic [NumFifos-1:0] adv;
    wr_t  w;
    adv_t a;
    int   id;
    adv = '0;
    push_valid   = v;
    push_fifo_id = ids;
    for (int p = 0; p < NumWritePorts; p++) push_data[p*Width +: Width] = Width'($urandom);
    for (int p = 0; p < NumWritePorts; p++) begin
      if (v[p]) begin
        id     = int'(ids[p]);
        w.port = p;
        w.addr = tail_m[id];
        w.data = push_data[p*Width +: Width];
        wr_q.push_back(w);
        tail_m[id] = (tail_m[id] == bound_m[id]) ? base_m[id] : AW'(tail_m[id] + 1);
        adv[id] = 1'b1;
      end
    end
    if (adv != '0) begin
      a.adv   = adv;
      a.tnext = flat_tails();
      adv_q.push_back(a);
    end
    @(posedge clk); #1;
    push_valid = '0;
    check_eq("tail", 32'(tail), 32'(flat_tails()));
  endtask

  // {withhold0, stall0, dealloc0} -> expected {credit0, count0, available0, receiver_in_reset}
  int unsigned row_w   [12] = '{1,1,1,1,1, 0,0,0,1,1,1,1};
  int unsigned row_s   [12] = '{0,0,0,0,0, 0,1,1,0,0,0,0};
  int unsigned row_d   [12] = '{0,0,0,0,0, 0,2,2,0,0,0,0};
  int unsigned exp_cr  [12] = '{0,2,1,0,0, 0,1,0,0,2,1,0};
  int unsigned exp_cnt [12] = '{4,4,2,1,1, 1,1,2,4,4,2,1};
  int unsigned exp_av  [12] = '{3,3,1,0,0, 1,1,2,3,3,1,0};
  int unsigned exp_rir [12] = '{1,0,0,0,0, 0,0,0,0,0,0,0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    push_sender_in_reset = 1'b0;
    push_valid = '0;
    push_data = '0;
    push_fifo_id = '0;
    config_base  = {3'd4, 3'd0};
    config_bound = {3'd7, 3'd3};
    config_size  = {4'd4, 4'd4};
    credit_initial_push  = {4'd4, 4'd4};
    credit_withhold_push = {4'd0, 4'd1};
    push_credit_stall = 2'b10;
    dealloc_count = '0;
    for (int f = 0; f < NumFifos; f++) tail_m[f] = base_m[f];

    @(negedge clk);
    check_eq("rst_tail", 32'(tail), 32'({3'd4, 3'd0}));
    check_eq("rst_wr_valid", 32'(ram_wr_valid), 32'd0);
    check_eq("rst_advance", 32'(advance_tail), 32'd0);
    check_eq("rst_credit", 32'(push_credit), 32'd0);
    check_eq("rst_count", 32'(credit_count_push), 32'({4'd4, 4'd4}));
    check_eq("rst_rir", 32'(push_receiver_in_reset), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      credit_withhold_push[CW-1:0] = CW'(row_w[i]);
      push_credit_stall[0] = row_s[i][0];
      dealloc_count[1:0] = 2'(row_d[i]);
      @(negedge clk);
      check_eq("credit0", 32'(push_credit[RW-1:0]), exp_cr[i]);
      check_eq("count0", 32'(credit_count_push[CW-1:0]), exp_cnt[i]);
      check_eq("avail0", 32'(credit_available_push[CW-1:0]), exp_av[i]);
      check_eq("rir", 32'(push_receiver_in_reset), exp_rir[i]);
      check_eq("credit1_stalled", 32'(push_credit[2*RW-1:RW]), 32'd0);
      check_eq("count1", 32'(credit_count_push[2*CW-1:CW]), 32'd4);
      @(posedge clk); #1;
    end
    dealloc_count = '0;

    push_cycle(3'b011, 3'b000);  // fifo0 on ports 0,1: addrs 0,1
    push_cycle(3'b011, 3'b011);  // fifo1: addrs 4,5
    push_cycle(3'b111, 3'b111);  // fifo1 wraps mid-batch: 6,7,4
    push_cycle(3'b111, 3'b010);  // interleaved: f0 2, f1 5, f0 3
    for (int i = 0; i < 20; i++) push_cycle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    push_cycle(3'b101, 3'b001);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int f = 0; f < NumFifos; f++) tail_m[f] = base_m[f];
    @(negedge clk);
    check_eq("mid_rst_tail", 32'(tail), 32'({3'd4, 3'd0}));
    check_eq("mid_rst_wr_valid", 32'(ram_wr_valid), 32'd0);
    check_eq("mid_rst_count", 32'(credit_count_push), 32'({4'd4, 4'd4}));
    check_eq("mid_rst_credit", 32'(push_credit), 32'd0);
    check_eq("mid_rst_rir", 32'(push_receiver_in_reset), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("post_rst_rir", 32'(push_receiver_in_reset), 32'd0);
    @(posedge clk); #1;

    push_cycle(3'b011, 3'b010);
    push_cycle(3'b110, 3'b100);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_eq("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    check_eq("adv_queue_empty", 32'(adv_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
